// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle for fp_div_seq: the FPU datapath is master, the divider is slave.
interface fp_div_seq_if;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] in_numA;
    logic [63:0] in_numB;
    logic        in_fmt;
    logic        out_valid;
    logic        in_ready;
    logic [63:0] out_result;
    logic [4:0]  out_flags;

    modport master (output in_valid, in_numA, in_numB, in_fmt, in_ready,
                    input  out_ready, out_valid, out_result, out_flags);
    modport slave  (input  in_valid, in_numA, in_numB, in_fmt, in_ready,
                    output out_ready, out_valid, out_result, out_flags);
endinterface

// File: rtl/fp_div_seq.sv
// Iterative restoring radix-2 FP32/FP64 divider, RNE, DAZ/FTZ, valid/ready on both sides.
// Define FP_DIV_SEQ_FLAGS_EN to compute and register out_flags; otherwise out_flags is tied to zero.
module fp_div_seq #(
    parameter int EXP_W_INT = 13,
    parameter int MAN_W     = 53
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    fp_div_seq_if.slave bus
);
    localparam int QW  = MAN_W + 2;   // quotient bits for FP64: hidden + frac + guard + norm spare
    localparam int RW  = MAN_W + 1;
    localparam int N32 = 26;

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, ROUND, DONE} state_t;

    state_t                       state_q, state_d;
    logic [63:0]                  a_q, a_d, b_q, b_d, res_q, res_d;
    logic                         fmt_q, fmt_d, sgn_q, sgn_d, spw_q, spw_d;
    logic signed [EXP_W_INT-1:0]  exp_q, exp_d;
    logic [MAN_W-1:0]             mb_q, mb_d;
    logic [RW-1:0]                rem_q, rem_d;
    logic [QW-1:0]                quo_q, quo_d;
    logic [5:0]                   cnt_q, cnt_d;

    // FP32 fields are widened so both formats share one classification path
    logic        sA, sB;
    logic [10:0] eA, eB, emax;
    logic [51:0] fA, fB;
    assign sA   = fmt_q ? a_q[63] : a_q[31];
    assign sB   = fmt_q ? b_q[63] : b_q[31];
    assign eA   = fmt_q ? a_q[62:52] : {3'b0, a_q[30:23]};
    assign eB   = fmt_q ? b_q[62:52] : {3'b0, b_q[30:23]};
    assign fA   = fmt_q ? a_q[51:0]  : {a_q[22:0], 29'b0};
    assign fB   = fmt_q ? b_q[51:0]  : {b_q[22:0], 29'b0};
    assign emax = fmt_q ? 11'h7FF : 11'h0FF;

    logic nanA, nanB, infA, infB, zA, zB, special, inv_nan;
    assign nanA    = (eA == emax) && (fA != '0);
    assign nanB    = (eB == emax) && (fB != '0);
    assign infA    = (eA == emax) && (fA == '0);
    assign infB    = (eB == emax) && (fB == '0);
    assign zA      = (eA == '0);
    assign zB      = (eB == '0);
    assign special = nanA | nanB | infA | infB | zA | zB;
    assign inv_nan = nanA | nanB | (zA & zB) | (infA & infB);

    logic        sgn_x;
    logic [63:0] inf_res, zero_res, nan_res, spc_res;
    assign sgn_x    = sA ^ sB;
    assign inf_res  = fmt_q ? {sgn_x, 11'h7FF, 52'b0} : {32'b0, sgn_x, 8'hFF, 23'b0};
    assign zero_res = fmt_q ? {sgn_x, 63'b0} : {32'b0, sgn_x, 31'b0};
    assign nan_res  = fmt_q ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
    assign spc_res  = inv_nan ? nan_res : (zB | infA) ? inf_res : zero_res;

    logic signed [EXP_W_INT-1:0] exp_un;
    assign exp_un = EXP_W_INT'(eA) - EXP_W_INT'(eB) + (fmt_q ? EXP_W_INT'(1023) : EXP_W_INT'(127));

    // restoring step: subtract divisor when it fits, then shift the partial remainder
    logic [RW:0]   diff;
    logic          qbit;
    logic [RW-1:0] rem_sel;
    assign diff    = {1'b0, rem_q} - {2'b0, mb_q};
    assign qbit    = ~diff[RW];
    assign rem_sel = qbit ? diff[RW-1:0] : rem_q;

    logic [QW-1:0] qa;
    assign qa = fmt_q ? quo_q : (quo_q << (QW - N32));

    // quotient is left-aligned after NORM: [QW-1] hidden, fraction, guard, then spare bits
    logic        lsb, grd, stk, rnd_up, carry, ovf, unf;
    logic [52:0] fr64;
    logic [23:0] fr32;
    logic signed [EXP_W_INT-1:0] exp_r, emax_s;
    assign lsb    = fmt_q ? quo_q[2] : quo_q[31];
    assign grd    = fmt_q ? quo_q[1] : quo_q[30];
    assign stk    = (rem_q != '0) | (fmt_q ? quo_q[0] : (quo_q[29:0] != '0));
    assign rnd_up = grd & (stk | lsb);
    assign fr64   = {1'b0, quo_q[QW-2:2]} + 53'(rnd_up);
    assign fr32   = {1'b0, quo_q[QW-2:QW-24]} + 24'(rnd_up);
    assign carry  = fmt_q ? fr64[52] : fr32[23];
    assign exp_r  = exp_q + EXP_W_INT'(carry);
    assign emax_s = fmt_q ? EXP_W_INT'(2047) : EXP_W_INT'(255);
    assign ovf    = ~exp_r[EXP_W_INT-1] & (exp_r >= emax_s);
    assign unf    = exp_r[EXP_W_INT-1] | (exp_r == '0);

`ifdef FP_DIV_SEQ_FLAGS_EN
    logic [4:0] flg_q, flg_d, spc_flg;
    logic       snan;
    assign snan    = (nanA & ~fA[51]) | (nanB & ~fB[51]);
    assign spc_flg = inv_nan ? {snan | (zA & zB) | (infA & infB), 4'b0}
                             : (zB & ~infA) ? 5'b01000 : 5'b00000;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fmt_d   = fmt_q;
        sgn_d   = sgn_q;
        spw_d   = spw_q;
        exp_d   = exp_q;
        mb_d    = mb_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
`ifdef FP_DIV_SEQ_FLAGS_EN
        flg_d   = flg_q;
`endif
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.in_numA;
                b_d     = bus.in_numB;
                fmt_d   = bus.in_fmt;
                state_d = UNPACK;
            end
            UNPACK: begin
                sgn_d = sgn_x;
                if (special) begin
                    // specials hold one extra cycle so their result appears two cycles after accept
                    spw_d = ~spw_q;
                    if (spw_q) begin
                        res_d   = spc_res;
`ifdef FP_DIV_SEQ_FLAGS_EN
                        flg_d   = spc_flg;
`endif
                        state_d = DONE;
                    end
                end else begin
                    exp_d   = exp_un;
                    mb_d    = {1'b1, fB};
                    rem_d   = {2'b01, fA};
                    quo_d   = '0;
                    cnt_d   = fmt_q ? 6'(QW) : 6'(N32);
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                rem_d = {rem_sel[RW-2:0], 1'b0};
                quo_d = {quo_q[QW-2:0], qbit};
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) state_d = NORM;
            end
            NORM: begin
                quo_d   = qa[QW-1] ? qa : {qa[QW-2:0], 1'b0};
                exp_d   = qa[QW-1] ? exp_q : exp_q - EXP_W_INT'(1);
                state_d = ROUND;
            end
            ROUND: begin
                if (ovf)
                    res_d = fmt_q ? {sgn_q, 11'h7FF, 52'b0} : {32'b0, sgn_q, 8'hFF, 23'b0};
                else if (unf)
                    res_d = fmt_q ? {sgn_q, 63'b0} : {32'b0, sgn_q, 31'b0};
                else
                    res_d = fmt_q ? {sgn_q, exp_r[10:0], fr64[51:0]}
                                  : {32'b0, sgn_q, exp_r[7:0], fr32[22:0]};
`ifdef FP_DIV_SEQ_FLAGS_EN
                flg_d   = ovf ? 5'b00101 : unf ? 5'b00011 : {4'b0, grd | stk};
`endif
                state_d = DONE;
            end
            DONE: if (bus.in_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fmt_q   <= 1'b0;
            sgn_q   <= 1'b0;
            spw_q   <= 1'b0;
            exp_q   <= '0;
            mb_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
`ifdef FP_DIV_SEQ_FLAGS_EN
            flg_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fmt_q   <= fmt_d;
            sgn_q   <= sgn_d;
            spw_q   <= spw_d;
            exp_q   <= exp_d;
            mb_q    <= mb_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
`ifdef FP_DIV_SEQ_FLAGS_EN
            flg_q   <= flg_d;
`endif
        end
    end

    assign bus.out_ready  = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q;
`ifdef FP_DIV_SEQ_FLAGS_EN
    assign bus.out_flags  = flg_q;
`else
    assign bus.out_flags  = 5'b0;
`endif
endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: arithmetic, specials, range limits, back-pressure, mid-op reset.
module tb_fp_div_seq;
`ifdef FP_DIV_SEQ_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;

    fp_div_seq_if bus();

    fp_div_seq #(.EXP_W_INT(13), .MAN_W(53)) dut (
        .in_clk  (clk),
        .in_rst_n(rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int lat);
        int k = 0;
        while (bus.out_valid !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        check($sformatf("%s latency", tag), 64'(k), 64'(lat));
    endtask

    task automatic finish_hs(input string tag);
        bus.in_ready = 1'b1;
        tick();
        bus.in_ready = 1'b0;
        check($sformatf("%s valid drop", tag), 64'(bus.out_valid), 64'd0);
        check($sformatf("%s ready back", tag), 64'(bus.out_ready), 64'd1);
    endtask

    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic fmt, input logic [63:0] res, input logic [4:0] flg,
                       input int lat);
        check($sformatf("%s ready idle", tag), 64'(bus.out_ready), 64'd1);
        bus.in_numA  = a;
        bus.in_numB  = b;
        bus.in_fmt   = fmt;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_valid(tag, lat);
        check($sformatf("%s result", tag), bus.out_result, res);
        check($sformatf("%s flags", tag), 64'(bus.out_flags), 64'(FLAGS_EN ? flg : 5'b0));
        finish_hs(tag);
    endtask

    initial begin
        int seen;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_ready = 1'b0;
        bus.in_numA  = '0;
        bus.in_numB  = '0;
        bus.in_fmt   = 1'b0;
        #12;
        check("rst out_ready", 64'(bus.out_ready), 64'd1);
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst out_result", bus.out_result, 64'd0);
        check("rst out_flags", 64'(bus.out_flags), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run("fp64 6/2", 64'h4018000000000000, 64'h4000000000000000, 1'b1,
            64'h4008000000000000, 5'b00000, 58);
        run("fp32 1/3", 64'h3F800000, 64'h40400000, 1'b0,
            64'h000000003EAAAAAB, 5'b00001, 29);
        run("fp32 -6/2", 64'hC0C00000, 64'h40000000, 1'b0,
            64'h00000000C0400000, 5'b00000, 29);
        run("fp64 1/0", 64'h3FF0000000000000, 64'h0, 1'b1,
            64'h7FF0000000000000, 5'b01000, 2);
        run("fp64 0/0", 64'h0, 64'h0, 1'b1,
            64'h7FF8000000000000, 5'b10000, 2);
        run("fp32 inf/1", 64'h7F800000, 64'h3F800000, 1'b0,
            64'h000000007F800000, 5'b00000, 2);
        run("fp32 snan/1", 64'h7F800001, 64'h3F800000, 1'b0,
            64'h000000007FC00000, 5'b10000, 2);
        run("fp64 ovf", 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000, 1'b1,
            64'h7FF0000000000000, 5'b00101, 58);
        run("fp64 unf", 64'h0010000000000000, 64'h4000000000000000, 1'b1,
            64'h0000000000000000, 5'b00011, 58);

        // back-pressure: result held, next operand waits until the result handshake
        bus.in_numA  = 64'h4018000000000000;
        bus.in_numB  = 64'h4000000000000000;
        bus.in_fmt   = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_valid("bp first", 58);
        bus.in_numA  = 64'h3F800000;
        bus.in_numB  = 64'h40400000;
        bus.in_fmt   = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("bp hold valid %0d", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("bp hold result %0d", i), bus.out_result, 64'h4008000000000000);
            check($sformatf("bp hold ready %0d", i), 64'(bus.out_ready), 64'd0);
        end
        finish_hs("bp first");
        tick();
        bus.in_valid = 1'b0;
        check("bp second accepted", 64'(bus.out_ready), 64'd0);
        wait_valid("bp second", 29);
        check("bp second result", bus.out_result, 64'h000000003EAAAAAB);
        finish_hs("bp second");

        // reset in the middle of DIVIDE
        bus.in_numA  = 64'h4018000000000000;
        bus.in_numB  = 64'h4000000000000000;
        bus.in_fmt   = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("mid busy", 64'(bus.out_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid rst valid", 64'(bus.out_valid), 64'd0);
        check("mid rst ready", 64'(bus.out_ready), 64'd1);
        check("mid rst result", bus.out_result, 64'd0);
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.out_valid === 1'b1) seen++;
        end
        check("mid no result", 64'(seen), 64'd0);
        run("post rst 1/3", 64'h3F800000, 64'h40400000, 1'b0,
            64'h000000003EAAAAAB, 5'b00001, 29);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
